// File: rtl/alu_pkg.sv
// Shared constants for the RV32I execute-stage ALU.
// The op codes are {funct7[5], funct3}.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/alu_addsub.sv
// Shared 33-bit adder/subtractor. In subtract mode the extra bit is the borrow,
// which is also the unsigned less-than result.
module alu_addsub
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            sub,
   output logic [XLEN-1:0] sum,
   output logic            carry,
   output logic            overflow
);

   logic [XLEN:0] wide;

   always_comb begin
      if (sub) begin
         wide = {1'b0, a} - {1'b0, b};
      end else begin
         wide = {1'b0, a} + {1'b0, b};
      end
   end

   assign sum   = wide[XLEN-1:0];
   assign carry = wide[XLEN];

   always_comb begin
      if (sub) begin
         overflow = (a[XLEN-1] != b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end else begin
         overflow = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
      end
   end

endmodule

// File: rtl/alu.sv
// Registered-output 32-bit RV32I ALU: combinational datapath, then the result
// and the ZF/CF/OF/SF flags are captured together on each rising edge.
module alu
   import alu_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      op,
   output logic [XLEN-1:0] out,
   output logic            ZF,
   output logic            CF,
   output logic            OF,
   output logic            SF
);

   logic [XLEN-1:0] sum;
   logic            carry;
   logic            ovf;
   logic            use_sub;
   logic [4:0]      shamt;
   logic            lt_signed;
   logic [XLEN-1:0] result;
   logic            cf_next;
   logic            of_next;

   // SLT and SLTU borrow the subtractor for their comparisons
   assign use_sub = (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
   assign shamt   = b[4:0];

   alu_addsub u_addsub (
      .a        (a),
      .b        (b),
      .sub      (use_sub),
      .sum      (sum),
      .carry    (carry),
      .overflow (ovf)
   );

   assign lt_signed = sum[XLEN-1] ^ ovf;

   always_comb begin
      result = b;
      case (op)
         ALU_ADD,
         ALU_SUB:  result = sum;
         ALU_SLL:  result = a << shamt;
         ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
         ALU_SLTU: result = {{(XLEN-1){1'b0}}, carry};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> shamt;
         ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = b;
      endcase
   end

   always_comb begin
      cf_next = 1'b0;
      of_next = 1'b0;
      if ((op == ALU_ADD) || (op == ALU_SUB)) begin
         cf_next = carry;
         of_next = ovf;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= '0;
         ZF  <= 1'b0;
         CF  <= 1'b0;
         OF  <= 1'b0;
         SF  <= 1'b0;
      end else begin
         out <= result;
         ZF  <= (result == '0);
         CF  <= cf_next;
         OF  <= of_next;
         SF  <= result[XLEN-1];
      end
   end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: expectations are queued when inputs are driven
// and compared one cycle later, so each result must appear exactly one cycle later.
module tb_alu;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  op = '0;
   logic [31:0] out;
   logic        ZF, CF, OF, SF;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [35:0] exp;
   } vec_t;

   logic [35:0] sb[$];
   vec_t        stim[$];

   always #5 clk = ~clk;

   alu dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .op  (op),
      .out (out),
      .ZF  (ZF),
      .CF  (CF),
      .OF  (OF),
      .SF  (SF)
   );

   // packed expectation: {out, ZF, CF, OF, SF}
   function automatic logic [35:0] pk(input logic [31:0] r, input logic z, input logic c,
                                      input logic v, input logic s);
      return {r, z, c, v, s};
   endfunction

   function automatic vec_t mk(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                               input logic [35:0] e);
      vec_t t;
      t.op = o; t.a = x; t.b = y; t.exp = e;
      return t;
   endfunction

   function automatic logic [35:0] model(input logic [3:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      logic [32:0] s;
      logic [31:0] r;
      logic        c, v;
      c = 1'b0; v = 1'b0; r = y;
      case (o)
         4'b0000: begin
            s = {1'b0, x} + {1'b0, y};
            r = s[31:0]; c = s[32];
            v = (x[31] == y[31]) && (r[31] != x[31]);
         end
         4'b1000: begin
            r = x - y; c = (x < y);
            v = (x[31] != y[31]) && (r[31] != x[31]);
         end
         4'b0001: r = x << y[4:0];
         4'b0010: r = {31'b0, ($signed(x) < $signed(y))};
         4'b0011: r = {31'b0, (x < y)};
         4'b0100: r = x ^ y;
         4'b0101: r = x >> y[4:0];
         4'b1101: r = $signed(x) >>> y[4:0];
         4'b0110: r = x | y;
         4'b0111: r = x & y;
         default: r = y;
      endcase
      return {r, (r == 32'h0), c, v, r[31]};
   endfunction

   task automatic test_reset();
      #1 rst = 1'b1;
      a = $urandom; b = $urandom; op = ALU_ADD;
      #1;
      checks++;
      if ({out, ZF, CF, OF, SF} !== 36'h0) begin
         errors++;
         $display("FAIL reset_initial got %h/%b%b%b%b need 0", out, ZF, CF, OF, SF);
      end
      @(negedge clk);
      rst = 1'b0;
      a = 32'd5; b = 32'd6; op = ALU_ADD;
      @(negedge clk);
      checks++;
      if ({out, ZF, CF, OF, SF} !== pk(32'd11, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_release got %h/%b%b%b%b need 0000000b/0000", out, ZF, CF, OF, SF);
      end
      a = 32'd1; b = 32'd2;
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({out, ZF, CF, OF, SF} !== 36'h0) begin
         errors++;
         $display("FAIL reset_async got %h/%b%b%b%b need 0", out, ZF, CF, OF, SF);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({out, ZF, CF, OF, SF} !== 36'h0) begin
         errors++;
         $display("FAIL reset_hold got %h/%b%b%b%b need 0", out, ZF, CF, OF, SF);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({out, ZF, CF, OF, SF} !== pk(32'd3, 0, 0, 0, 0)) begin
         errors++;
         $display("FAIL reset_first_edge got %h/%b%b%b%b need 00000003/0000", out, ZF, CF, OF, SF);
      end
   endtask

   task automatic test_arith();
      logic [35:0] e;
      stim = {};
      stim.push_back(mk(ALU_ADD, 32'hF0000001, 32'hF0000000, pk(32'hE0000001, 0, 1, 0, 1)));
      stim.push_back(mk(ALU_SUB, 32'h00000001, 32'h00000011, pk(32'hFFFFFFF0, 0, 1, 0, 1)));
      stim.push_back(mk(ALU_ADD, 32'h7FFFFFFF, 32'h00000001, pk(32'h80000000, 0, 0, 1, 1)));
      stim.push_back(mk(ALU_SUB, 32'h80000000, 32'h00000001, pk(32'h7FFFFFFF, 0, 0, 1, 0)));
      stim.push_back(mk(ALU_ADD, 32'hFFFFFFFF, 32'h00000001, pk(32'h00000000, 1, 1, 0, 0)));
      stim.push_back(mk(ALU_SUB, 32'h12345678, 32'h12345678, pk(32'h00000000, 1, 0, 0, 0)));
      for (int i = 0; i <= stim.size(); i++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({out, ZF, CF, OF, SF} !== e) begin
               errors++;
               $display("FAIL arith[%0d] got %h/%b%b%b%b need %h/%b", i - 1,
                        out, ZF, CF, OF, SF, e[35:4], e[3:0]);
            end
         end
         if (i < stim.size()) begin
            a = stim[i].a; b = stim[i].b; op = stim[i].op;
            sb.push_back(stim[i].exp);
         end
      end
   endtask

   task automatic test_shift_cmp();
      logic [35:0] e;
      stim = {};
      stim.push_back(mk(ALU_SLL,  32'hFFFFFFFF, 32'h00000001, pk(32'hFFFFFFFE, 0, 0, 0, 1)));
      stim.push_back(mk(ALU_SLT,  32'hF0000001, 32'h00000010, pk(32'h00000001, 0, 0, 0, 0)));
      stim.push_back(mk(ALU_SLTU, 32'h00000001, 32'h00000010, pk(32'h00000001, 0, 0, 0, 0)));
      stim.push_back(mk(ALU_SLTU, 32'hF0000001, 32'h00000010, pk(32'h00000000, 1, 0, 0, 0)));
      stim.push_back(mk(ALU_SRL,  32'h00000001, 32'h00000001, pk(32'h00000000, 1, 0, 0, 0)));
      stim.push_back(mk(ALU_SRA,  32'h80000000, 32'h00000004, pk(32'hF8000000, 0, 0, 0, 1)));
      stim.push_back(mk(ALU_SRL,  32'h80000000, 32'hFFFFFFE4, pk(32'h08000000, 0, 0, 0, 0)));
      stim.push_back(mk(ALU_SLL,  32'h00000001, 32'h0000003F, pk(32'h80000000, 0, 0, 0, 1)));
      for (int i = 0; i <= stim.size(); i++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({out, ZF, CF, OF, SF} !== e) begin
               errors++;
               $display("FAIL shift_cmp[%0d] got %h/%b%b%b%b need %h/%b", i - 1,
                        out, ZF, CF, OF, SF, e[35:4], e[3:0]);
            end
         end
         if (i < stim.size()) begin
            a = stim[i].a; b = stim[i].b; op = stim[i].op;
            sb.push_back(stim[i].exp);
         end
      end
   endtask

   task automatic test_logic_pass();
      logic [35:0] e;
      stim = {};
      stim.push_back(mk(ALU_XOR, 32'h00000001, 32'h00000011, pk(32'h00000010, 0, 0, 0, 0)));
      stim.push_back(mk(ALU_OR,  32'h00000001, 32'h00000011, pk(32'h00000011, 0, 0, 0, 0)));
      stim.push_back(mk(ALU_AND, 32'h00000001, 32'h00000011, pk(32'h00000001, 0, 0, 0, 0)));
      stim.push_back(mk(4'b1010, 32'hFFFFFFFF, 32'h00000000, pk(32'h00000000, 1, 0, 0, 0)));
      stim.push_back(mk(4'b1011, 32'h7FFFFFFF, 32'h00000000, pk(32'h00000000, 1, 0, 0, 0)));
      stim.push_back(mk(4'b1111, 32'h7FFFFFFF, 32'h12345000, pk(32'h12345000, 0, 0, 0, 0)));
      stim.push_back(mk(4'b1001, 32'hFFFFFFFF, 32'h80000001, pk(32'h80000001, 0, 0, 0, 1)));
      for (int i = 0; i <= stim.size(); i++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({out, ZF, CF, OF, SF} !== e) begin
               errors++;
               $display("FAIL logic_pass[%0d] got %h/%b%b%b%b need %h/%b", i - 1,
                        out, ZF, CF, OF, SF, e[35:4], e[3:0]);
            end
         end
         if (i < stim.size()) begin
            a = stim[i].a; b = stim[i].b; op = stim[i].op;
            sb.push_back(stim[i].exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [35:0] e;
      logic [31:0] specials[6];
      logic [31:0] x, y;
      logic [3:0]  o;
      specials = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0000001F};
      for (int i = 0; i <= 64; i++) begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({out, ZF, CF, OF, SF} !== e) begin
               errors++;
               $display("FAIL back_to_back[%0d] got %h/%b%b%b%b need %h/%b", i - 1,
                        out, ZF, CF, OF, SF, e[35:4], e[3:0]);
            end
         end
         if (i < 64) begin
            o = 4'($urandom_range(0, 15));
            x = (i % 3 == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            y = (i % 4 == 1) ? specials[$urandom_range(0, 5)] : $urandom;
            a = x; b = y; op = o;
            sb.push_back(model(o, x, y));
         end
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_shift_cmp();
      test_logic_pass();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
